// File: rtl/multi_sel_pkg.sv
// Shared types and helpers for the multi-coefficient multiply sequencer.
// Holds the state enum, the default coefficient table and the table lookup function.
package multi_sel_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Widest packed coefficient table the lookup helper accepts.
    localparam int COEF_TBL_W = 256;

    localparam logic [15:0] DEF_COEFS = {4'd8, 4'd7, 4'd3, 4'd1};

    function automatic logic [31:0] coef_at(input logic [COEF_TBL_W-1:0] coefs,
                                            input int i, input int cw);
        logic [COEF_TBL_W-1:0] mask;
        mask = (COEF_TBL_W'(1) << cw) - COEF_TBL_W'(1);
        return 32'((coefs >> (i * cw)) & mask);
    endfunction

endpackage

// File: rtl/multi_sel_shiftadd.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, CW cycles per product.
// done/product are valid together in the final cycle; product includes that last partial.
module multi_sel_shiftadd #(
    parameter int DW = 8,
    parameter int CW = 4,
    parameter int OW = DW + CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] operand,
    input  logic [CW-1:0] coef,
    output logic          busy,
    output logic          done,
    output logic [OW-1:0] product
);
    localparam int CNTW = $clog2(CW + 1);

    logic [OW-1:0]   acc, mcand, partial;
    logic [CW-1:0]   mplier;
    logic [CNTW-1:0] cnt;

    assign partial = mplier[0] ? mcand : '0;
    assign done    = busy & (cnt == CNTW'(1));
    assign product = acc + partial;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= OW'(operand);
            mplier <= coef;
            cnt    <= CNTW'(CW);
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= acc + partial;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CNTW'(1);
            if (cnt == CNTW'(1))
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/multi_sel_seq.sv
// Operand-in, NCOEF-product-out sequencer with backpressured, index/last-tagged beats.
// Define MULTI_SEL_SHIFTADD_EN to build products with the iterative shift-add unit.
module multi_sel_seq
    import multi_sel_pkg::*;
#(
    parameter int                   DW    = 8,
    parameter int                   NCOEF = 4,
    parameter int                   CW    = 4,
    parameter logic [NCOEF*CW-1:0]  COEFS = DEF_COEFS,
    parameter int                   OW    = DW + CW,
    parameter int                   IW    = $clog2(NCOEF)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [OW-1:0] out_data,
    output logic [IW-1:0] out_idx,
    output logic          out_last,
    input  logic          out_ready
);
    state_t        state, state_nxt;
    logic [DW-1:0] op_q;
    logic [IW-1:0] idx_q, idx_nxt;
    logic [OW-1:0] out_data_q;
    logic          last, hs, accept;
    logic [CW-1:0] coef_tbl [NCOEF];

    for (genvar i = 0; i < NCOEF; i++) begin : g_coef
        assign coef_tbl[i] = CW'(coef_at(COEF_TBL_W'(COEFS), i, CW));
    end

    assign last    = (idx_q == IW'(NCOEF - 1));
    assign hs      = out_valid & out_ready;
    assign accept  = in_valid & in_ready;
    assign idx_nxt = last ? '0 : idx_q + IW'(1);

`ifdef MULTI_SEL_SHIFTADD_EN
    localparam state_t LOAD_ST = CALC;
    logic          start_q, sa_start, sa_busy, sa_done;
    logic [CW-1:0] sa_coef;
    logic [OW-1:0] sa_product;

    // Beat 0 starts a cycle after accept (operand must be latched first);
    // later beats start straight off the handshake.
    assign sa_start = start_q | (hs & ~last);
    assign sa_coef  = start_q ? coef_tbl[idx_q] : coef_tbl[idx_nxt];

    multi_sel_shiftadd #(.DW(DW), .CW(CW), .OW(OW)) u_shiftadd (
        .clk     (clk),
        .rst     (rst),
        .start   (sa_start),
        .operand (op_q),
        .coef    (sa_coef),
        .busy    (sa_busy),
        .done    (sa_done),
        .product (sa_product)
    );
`else
    localparam state_t LOAD_ST = HOLD;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = LOAD_ST;
            HOLD: if (hs) begin
                if (!last)         state_nxt = LOAD_ST;
                else if (in_valid) state_nxt = LOAD_ST;
                else               state_nxt = IDLE;
            end
`ifdef MULTI_SEL_SHIFTADD_EN
            CALC: if (sa_busy && sa_done) state_nxt = HOLD;
`else
            CALC: state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state == HOLD);
        out_last  = out_valid & last;
        in_ready  = (state == IDLE) | (out_valid & out_ready & last);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= '0;
            idx_q      <= '0;
            out_data_q <= '0;
`ifdef MULTI_SEL_SHIFTADD_EN
            start_q    <= 1'b0;
`endif
        end else begin
`ifdef MULTI_SEL_SHIFTADD_EN
            start_q <= accept;
            if (accept) begin
                op_q  <= in_data;
                idx_q <= '0;
            end else if (hs && !last) begin
                idx_q <= idx_nxt;
            end
            if (state == CALC && sa_done)
                out_data_q <= sa_product;
`else
            if (accept) begin
                op_q       <= in_data;
                idx_q      <= '0;
                out_data_q <= OW'(in_data) * OW'(coef_tbl[0]);
            end else if (hs && !last) begin
                idx_q      <= idx_nxt;
                out_data_q <= OW'(op_q) * OW'(coef_tbl[idx_nxt]);
            end
`endif
        end
    end

    assign out_data = out_data_q;
    assign out_idx  = idx_q;

endmodule
